date_display_scan: RTL

// - Reader/consumer side of the watch date counter: samples binary year/month/day,

---
 rtl/date_display_scan_pkg.sv | 47 ++++
 rtl/date_display_scan_bin2bcd_seq.sv | 53 +++++
 rtl/date_display_scan.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/date_display_scan_pkg.sv
// Shared types and constants for the date display scanner: FSM states,
// 4-bit digit codes, 7-segment lookup and separator-dot positions.
package date_display_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_Y,
    S_CONV_M,
    S_CONV_D,
    S_COMMIT
  } state_t;

  // Converter operand width and shifts per field (one shift per cycle).
  localparam int         BCD_IN_W    = 15;
  localparam logic [3:0] CONV_CYCLES = 4'd15;

  localparam int NUM_DIGITS = 8;

  // Digit codes 0-9 are plain BCD; these two are the non-numeric glyphs.
  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  // Digit positions carrying the separator dot: year units and month units.
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 8'b0001_0100;

  // Digit code to {g,f,e,d,c,b,a}; BLANK and any unused code go dark.
  function automatic logic [6:0] seg7(input logic [3:0] dig);
    logic [6:0] s;
    s = 7'h00;
    case (dig)
      4'h0:     s = 7'h3F;
      4'h1:     s = 7'h06;
      4'h2:     s = 7'h5B;
      4'h3:     s = 7'h4F;
      4'h4:     s = 7'h66;
      4'h5:     s = 7'h6D;
      4'h6:     s = 7'h7D;
      4'h7:     s = 7'h07;
      4'h8:     s = 7'h7F;
      4'h9:     s = 7'h6F;
      DIG_DASH: s = 7'h40;
      default:  s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/date_display_scan_bin2bcd_seq.sv
// Sequential double-dabble converter: 15-bit binary in, low 4 BCD digits out.
// A start pulse loads the operand; 15 shift-add-3 steps follow, one per cycle.
// done is high during the last step and bcd then carries the final result,
// so the caller can capture it and restart on the same edge.
module date_display_scan_bin2bcd_seq
  import date_display_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BCD_IN_W-1:0] bin_in,
  output logic                done,
  output logic [15:0]         bcd
);

  logic [BCD_IN_W-1:0] bin_q;
  logic [15:0]         bcd_q;
  logic [15:0]         bcd_adj;
  logic [15:0]         bcd_nxt;
  logic [3:0]          cnt_q;

  // Add-3 correction on every digit >= 5, then shift in the next binary bit.
  // Digits above the fourth are dropped; they never feed back into lower ones.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      else                         bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
    end
    bcd_nxt = {bcd_adj[14:0], bin_q[BCD_IN_W-1]};
  end

  assign done = (cnt_q == 4'd1);
  assign bcd  = bcd_nxt;

  // Operand load on start, otherwise one shift step per cycle until the step counter expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= bin_in;
      bcd_q <= '0;
      cnt_q <= CONV_CYCLES;
    end else if (cnt_q != 4'd0) begin
      bin_q <= {bin_q[BCD_IN_W-2:0], 1'b0};
      bcd_q <= bcd_nxt;
      cnt_q <= cnt_q - 4'd1;
    end
  end

endmodule

// File: rtl/date_display_scan.sv
// Date display scanner: snapshots year/month/day, converts each field to BCD
// with one shared sequential converter, commits all eight digits at once and
// scans them onto a multiplexed 7-segment display as YYYY.MM.DD.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for force_req or a refresh hit on scan_tick
//   S_CONV_Y | converting the year snapshot (15 cycles)
//   S_CONV_M | converting the month snapshot (15 cycles)
//   S_CONV_D | converting the day snapshot (15 cycles)
//   S_COMMIT | staged digits copied to display regs; pending force restarts
module date_display_scan
  import date_display_scan_pkg::*;
#(
  parameter int YEAR_W        = 15,
  parameter int MD_W          = 7,
  parameter int REFRESH_TICKS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_tick,
  input  logic              force_req,
  input  logic [YEAR_W-1:0] year,
  input  logic [MD_W-1:0]   month,
  input  logic [MD_W-1:0]   day,
  output logic [7:0]        an,
  output logic [7:0]        seg,
  output logic              busy
);

  localparam int                RC_W     = $clog2(REFRESH_TICKS);
  localparam logic [RC_W-1:0]   RC_LOAD  = RC_W'(REFRESH_TICKS - 1);
  localparam logic [YEAR_W-1:0] YEAR_MAX = YEAR_W'(9999);
  localparam logic [MD_W-1:0]   MD_MAX   = MD_W'(99);

  state_t              state_q;
  logic                pend_q;
  logic [MD_W-1:0]     month_q;
  logic [MD_W-1:0]     day_q;
  logic                yr_oor_q;
  logic                mo_oor_q;
  logic                dy_oor_q;
  logic [3:0]          stg_q  [NUM_DIGITS];
  logic [3:0]          disp_q [NUM_DIGITS];
  logic [RC_W-1:0]     rcnt_q;
  logic [2:0]          scan_idx_q;
  logic [2:0]          scan_nxt;

  logic                refresh_hit;
  logic                trigger;
  logic                cv_start;
  logic [BCD_IN_W-1:0] cv_in;
  logic                cv_done;
  logic [15:0]         cv_bcd;

  assign refresh_hit = scan_tick && (rcnt_q == RC_LOAD);
  assign scan_nxt    = scan_idx_q + 3'd1;

  // A refresh hit only starts a conversion from IDLE; the COMMIT cycle
  // restarts only for a force (pending or arriving), so back-to-back forces
  // keep busy high without an idle gap.
  always_comb begin
    trigger = 1'b0;
    if (state_q == S_IDLE)        trigger = force_req || refresh_hit;
    else if (state_q == S_COMMIT) trigger = pend_q || force_req;
  end

  // Converter start and operand: year straight from the input on the trigger
  // edge, month/day from the snapshot as the previous field finishes.
  always_comb begin
    cv_start = 1'b0;
    cv_in    = '0;
    if (trigger) begin
      cv_start = 1'b1;
      cv_in    = BCD_IN_W'(year);
    end else if (cv_done && state_q == S_CONV_Y) begin
      cv_start = 1'b1;
      cv_in    = BCD_IN_W'(month_q);
    end else if (cv_done && state_q == S_CONV_M) begin
      cv_start = 1'b1;
      cv_in    = BCD_IN_W'(day_q);
    end
  end

  date_display_scan_bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (cv_start),
    .bin_in (cv_in),
    .done   (cv_done),
    .bcd    (cv_bcd)
  );

  // Conversion sequencer: snapshot, per-field capture into staging, pending force.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy     <= 1'b0;
      pend_q   <= 1'b0;
      month_q  <= '0;
      day_q    <= '0;
      yr_oor_q <= 1'b0;
      mo_oor_q <= 1'b0;
      dy_oor_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) stg_q[i] <= DIG_BLANK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_q <= S_CONV_Y;
            busy    <= 1'b1;
          end
        end
        S_CONV_Y: begin
          if (force_req) pend_q <= 1'b1;
          if (cv_done) begin
            stg_q[7] <= yr_oor_q ? DIG_DASH : cv_bcd[15:12];
            stg_q[6] <= yr_oor_q ? DIG_DASH : cv_bcd[11:8];
            stg_q[5] <= yr_oor_q ? DIG_DASH : cv_bcd[7:4];
            stg_q[4] <= yr_oor_q ? DIG_DASH : cv_bcd[3:0];
            state_q  <= S_CONV_M;
          end
        end
        S_CONV_M: begin
          if (force_req) pend_q <= 1'b1;
          if (cv_done) begin
            stg_q[3] <= mo_oor_q ? DIG_DASH : cv_bcd[7:4];
            stg_q[2] <= mo_oor_q ? DIG_DASH : cv_bcd[3:0];
            state_q  <= S_CONV_D;
          end
        end
        S_CONV_D: begin
          if (force_req) pend_q <= 1'b1;
          if (cv_done) begin
            stg_q[1] <= dy_oor_q ? DIG_DASH : cv_bcd[7:4];
            stg_q[0] <= dy_oor_q ? DIG_DASH : cv_bcd[3:0];
            state_q  <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (trigger) begin
            state_q <= S_CONV_Y;
            pend_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
      if (trigger) begin
        month_q  <= month;
        day_q    <= day;
        yr_oor_q <= (year > YEAR_MAX);
        mo_oor_q <= (month > MD_MAX);
        dy_oor_q <= (day > MD_MAX);
      end
    end
  end

  // Display digits change only on the edge leaving COMMIT, all eight together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) disp_q[i] <= DIG_BLANK;
    end else if (state_q == S_COMMIT) begin
      for (int i = 0; i < NUM_DIGITS; i++) disp_q[i] <= stg_q[i];
    end
  end

  // Digit scan and refresh down-counter, both stepped by scan_tick only.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx_q <= 3'd0;
      an         <= 8'h01;
      seg        <= 8'h00;
      rcnt_q     <= RC_LOAD;
    end else if (scan_tick) begin
      scan_idx_q <= scan_nxt;
      an         <= {an[6:0], an[7]};
      seg        <= {DP_MASK[scan_nxt] && (disp_q[scan_nxt] != DIG_BLANK),
                     seg7(disp_q[scan_nxt])};
      rcnt_q     <= (rcnt_q == '0) ? RC_LOAD : rcnt_q - 1'b1;
    end
  end

endmodule
